mem_channel_arbiter: RTL
========================

// Module: mem_channel_arbiter
// PURPOSE
//  Shares NUM_CHANNELS external memory channels among NUM_CONSUMERS LSU requesters.
//  Each channel runs its own FSM: it claims one pending consumer request, forwards it
//  to memory, returns the ready/data, then waits for the consumer to release it.
//  Sits between the per-thread LSUs of all cores and the external data/program memory.
// PARAMETERS
//  ADDR_BITS      8  memory address width
//  DATA_BITS      8  memory data width
//  NUM_CONSUMERS  4  number of LSU requesters
//  NUM_CHANNELS   1  concurrent memory channels, 1..NUM_CONSUMERS
//  WRITE_ENABLE   1  0 = read-only memory: write path absent, write outputs tied 0
// PORTS  (per-index buses flattened, index i at [i*W +: W])
//  clk                    in   1                  clock
//  reset                  in   1                  synchronous, active-high
//  consumer_read_valid    in   NUM_CONSUMERS      read request, held until ready seen
//  consumer_read_address  in   NUM_CONSUMERS*ADDR read address
//  consumer_read_ready    out  NUM_CONSUMERS      read done; held until valid drops
//  consumer_read_data     out  NUM_CONSUMERS*DATA read data, valid while ready=1
//  consumer_write_valid   in   NUM_CONSUMERS      write request
//  consumer_write_address in   NUM_CONSUMERS*ADDR write address
//  consumer_write_data    in   NUM_CONSUMERS*DATA write data
//  consumer_write_ready   out  NUM_CONSUMERS      write done; held until valid drops
//  mem_read_valid         out  NUM_CHANNELS       channel read request
//  mem_read_address       out  NUM_CHANNELS*ADDR
//  mem_read_ready         in   NUM_CHANNELS       memory read complete
//  mem_read_data          in   NUM_CHANNELS*DATA
//  mem_write_valid        out  NUM_CHANNELS
//  mem_write_address      out  NUM_CHANNELS*ADDR
//  mem_write_data         out  NUM_CHANNELS*DATA
//  mem_write_ready        in   NUM_CHANNELS       memory write complete
// BEHAVIOUR
//  - Reset: all outputs 0, all channels IDLE, all consumer-claimed flags 0, RR pointers 0.
//  - Channel FSM: IDLE -> READ_WAIT | WRITE_WAIT -> RELAY_READ | RELAY_WRITE -> IDLE.
//  - IDLE: scan consumers; first unclaimed consumer with read_valid or write_valid is
//    claimed; read wins if both asserted by same consumer. Registered: mem_*_valid,
//    address (and write data) appear the cycle after consumer valid is sampled.
//  - Channels resolve in ascending channel index within a cycle; a consumer claimed by a
//    lower channel is invisible to higher channels that same cycle (no double grant).
//  - READ_WAIT: on mem_read_ready: mem_read_valid<=0, consumer_read_ready<=1,
//    consumer_read_data<=mem_read_data, -> RELAY_READ. WRITE_WAIT analogous, no data.
//  - RELAY_*: hold consumer ready/data until consumer valid samples 0; then ready<=0,
//    claimed flag cleared, -> IDLE. Channel may re-grant the cycle after entering IDLE.
//  - Best-case read turnaround: valid@N, mem valid N+1, mem ready@N+1 -> consumer ready
//    N+2; valid drop sampled N+3 -> ready 0 and IDLE at N+4.
//  - mem_*_ready while channel not in matching WAIT state: ignored.
//  - Consumer valid dropping during *_WAIT (protocol violation): request still completes;
//    RELAY exits on first sampled valid=0.
//  - WRITE_ENABLE=0: write valids ignored, never claimed; write outputs constant 0.
//  - Reset mid-transaction: everything returns to reset values next cycle; in-flight
//    memory access abandoned, no ready ever issued for it.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: each channel scans from (last granted consumer + 1)
//    mod NUM_CONSUMERS; pointer updates on grant only.
//  Undefined: fixed priority, every scan starts at consumer 0 (lowest index wins).
// TESTING
//  1 Single read: C=4,CH=1; consumer 2 reads 0x10, mem ready next cycle with 0xA5 ->
//    consumer_read_ready[2]=1, data 0xA5 at N+2; release -> ready 0, channel IDLE.
//  2 Write: consumer 1 writes 0x3C to 0x20 -> mem_write_valid=1, addr 0x20, data 0x3C;
//    mem_write_ready -> consumer_write_ready[1]=1 until consumer valid drops.
//  3 Contention CH=1, consumers 0,1,3 read together: fixed -> order 0,1,3 repeated on
//    re-request 0,1,...; RR_EN -> grants 0,1,3,0 with 0 re-requesting, no starvation.
//  4 CH=2, all 4 consumers request same cycle: channel0 takes C0, channel1 takes C1,
//    never same consumer; remaining served as channels free; each served exactly once.
//  5 Consumer asserts read+write simultaneously -> read served first, write next grant.
//  6 Assert reset during READ_WAIT -> next cycle all outputs 0; late mem_read_ready
//    ignored; fresh request afterwards completes normally.

Source files
------------

// File: rtl/mem_channel_arbiter.sv
// mem_channel_arbiter: shares NUM_CHANNELS memory channels among NUM_CONSUMERS LSU requesters (MEM_ARB_ROUND_ROBIN_EN selects round-robin scan, else fixed priority)
module mem_channel_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);
  localparam int CW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
  typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY_READ, RELAY_WRITE} state_t;
  state_t state [NUM_CHANNELS];
  state_t next_state [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] grant, grant_rd;
  logic [NUM_CHANNELS-1:0][CW-1:0] grant_idx, owner;
  logic [NUM_CONSUMERS-1:0] claimed, taken;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [NUM_CHANNELS-1:0][CW-1:0] start;
`endif
  always_comb begin
    int i;
    i = 0;
    taken = claimed;
    grant = '0;
    grant_rd = '0;
    grant_idx = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        i = (int'(start[c]) + k) % NUM_CONSUMERS;
`else
        i = k;
`endif
        if (state[c] == IDLE && !grant[c] && !taken[i] &&
            (consumer_read_valid[i] || (WRITE_ENABLE != 0 && consumer_write_valid[i]))) begin
          grant[c] = 1'b1;
          grant_rd[c] = consumer_read_valid[i];
          grant_idx[c] = CW'(i);
          taken[i] = 1'b1;
        end
      end
    end
  end
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      next_state[c] = state[c];
      case (state[c])
        IDLE:        next_state[c] = grant[c] ? (grant_rd[c] ? READ_WAIT : WRITE_WAIT) : IDLE;
        READ_WAIT:   next_state[c] = mem_read_ready[c] ? RELAY_READ : READ_WAIT;
        WRITE_WAIT:  next_state[c] = mem_write_ready[c] ? RELAY_WRITE : WRITE_WAIT;
        RELAY_READ:  next_state[c] = consumer_read_valid[owner[c]] ? RELAY_READ : IDLE;
        RELAY_WRITE: next_state[c] = consumer_write_valid[owner[c]] ? RELAY_WRITE : IDLE;
        default:     next_state[c] = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) state[c] <= reset ? IDLE : next_state[c];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      claimed <= '0;
      owner <= '0;
      consumer_read_ready <= '0;
      consumer_read_data <= '0;
      consumer_write_ready <= '0;
      mem_read_valid <= '0;
      mem_read_address <= '0;
      mem_write_valid <= '0;
      mem_write_address <= '0;
      mem_write_data <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      start <= '0;
`endif
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (grant[c]) begin
          owner[c] <= grant_idx[c];
          claimed[grant_idx[c]] <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          start[c] <= CW'((int'(grant_idx[c]) + 1) % NUM_CONSUMERS);
`endif
          if (grant_rd[c]) begin
            mem_read_valid[c] <= 1'b1;
            mem_read_address[c*ADDR_BITS +: ADDR_BITS] <= consumer_read_address[grant_idx[c]*ADDR_BITS +: ADDR_BITS];
          end else if (WRITE_ENABLE != 0) begin
            mem_write_valid[c] <= 1'b1;
            mem_write_address[c*ADDR_BITS +: ADDR_BITS] <= consumer_write_address[grant_idx[c]*ADDR_BITS +: ADDR_BITS];
            mem_write_data[c*DATA_BITS +: DATA_BITS] <= consumer_write_data[grant_idx[c]*DATA_BITS +: DATA_BITS];
          end
        end
        if (state[c] == READ_WAIT && mem_read_ready[c]) begin
          mem_read_valid[c] <= 1'b0;
          consumer_read_ready[owner[c]] <= 1'b1;
          consumer_read_data[owner[c]*DATA_BITS +: DATA_BITS] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
        end
        if (state[c] == WRITE_WAIT && mem_write_ready[c]) begin
          mem_write_valid[c] <= 1'b0;
          consumer_write_ready[owner[c]] <= 1'b1;
        end
        if (state[c] == RELAY_READ && !consumer_read_valid[owner[c]]) begin
          consumer_read_ready[owner[c]] <= 1'b0;
          claimed[owner[c]] <= 1'b0;
        end
        if (state[c] == RELAY_WRITE && !consumer_write_valid[owner[c]]) begin
          consumer_write_ready[owner[c]] <= 1'b0;
          claimed[owner[c]] <= 1'b0;
        end
      end
    end
  end
endmodule
